// File: rtl/axi_lite_mm_master.sv
// AXI4-Lite initiator: word-indexed MM read/write commands in,
// AXI4-Lite transactions out; independent read and write engines.
//
// Ports:
//   aclk, areset         clock, async active-high reset
//   i_mm_w* / o_mm_w*    write command (valid/ready), done pulse, bresp
//   i_mm_r* / o_mm_r*    read command (valid/ready), done pulse, data, rresp
//   o_axi_aw*/w*/b*      AXI write channels (AW, W, B)
//   o_axi_ar*/r*         AXI read channels (AR, R)
module axi_lite_mm_master #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ALIGN      = $clog2(STRB_WIDTH)
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        i_mm_wvalid,
  output logic                        o_mm_wready,
  input  logic [ADDR_WIDTH-ALIGN-1:0] i_mm_waddr,
  input  logic [DATA_WIDTH-1:0]       i_mm_wdata,
  input  logic [STRB_WIDTH-1:0]       i_mm_wstrb,
  input  logic [2:0]                  i_mm_wprot,
  output logic                        o_mm_wdone,
  output logic [1:0]                  o_mm_wresp,
  input  logic                        i_mm_rvalid,
  output logic                        o_mm_rready,
  input  logic [ADDR_WIDTH-ALIGN-1:0] i_mm_raddr,
  input  logic [2:0]                  i_mm_rprot,
  output logic                        o_mm_rdone,
  output logic [DATA_WIDTH-1:0]       o_mm_rdata,
  output logic [1:0]                  o_mm_rresp,
  output logic                        o_axi_awvalid,
  input  logic                        i_axi_awready,
  output logic [ADDR_WIDTH-1:0]       o_axi_awaddr,
  output logic [2:0]                  o_axi_awprot,
  output logic                        o_axi_wvalid,
  input  logic                        i_axi_wready,
  output logic [DATA_WIDTH-1:0]       o_axi_wdata,
  output logic [STRB_WIDTH-1:0]       o_axi_wstrb,
  input  logic                        i_axi_bvalid,
  output logic                        o_axi_bready,
  input  logic [1:0]                  i_axi_bresp,
  output logic                        o_axi_arvalid,
  input  logic                        i_axi_arready,
  output logic [ADDR_WIDTH-1:0]       o_axi_araddr,
  output logic [2:0]                  o_axi_arprot,
  input  logic                        i_axi_rvalid,
  output logic                        o_axi_rready,
  input  logic [DATA_WIDTH-1:0]       i_axi_rdata,
  input  logic [1:0]                  i_axi_rresp
);

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic                  aw_done, aw_done_n;
  logic                  w_done, w_done_n;
  logic                  mm_wready_n, awvalid_n, wvalid_n, bready_n;
  logic [ADDR_WIDTH-1:0] awaddr_n;
  logic [2:0]            awprot_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic [STRB_WIDTH-1:0] wstrb_n;
  logic                  wdone_n;
  logic [1:0]            wresp_n;

  logic                  mm_rready_n, arvalid_n, rready_n;
  logic [ADDR_WIDTH-1:0] araddr_n;
  logic [2:0]            arprot_n;
  logic                  rdone_n;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic [1:0]            rresp_n;

  logic aw_hs, w_hs;

  assign aw_hs = o_axi_awvalid & i_axi_awready;
  assign w_hs  = o_axi_wvalid & i_axi_wready;

  // Write engine
  always_comb begin
    w_state_n   = w_state;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    mm_wready_n = o_mm_wready;
    awvalid_n   = o_axi_awvalid;
    wvalid_n    = o_axi_wvalid;
    bready_n    = o_axi_bready;
    awaddr_n    = o_axi_awaddr;
    awprot_n    = o_axi_awprot;
    wdata_n     = o_axi_wdata;
    wstrb_n     = o_axi_wstrb;
    wresp_n     = o_mm_wresp;
    wdone_n     = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        mm_wready_n = 1'b1;
        if (o_mm_wready && i_mm_wvalid) begin
          mm_wready_n = 1'b0;
          awvalid_n   = 1'b1;
          wvalid_n    = 1'b1;
          aw_done_n   = 1'b0;
          w_done_n    = 1'b0;
          awaddr_n    = ADDR_WIDTH'(i_mm_waddr) << ALIGN;
          awprot_n    = i_mm_wprot;
          wdata_n     = i_mm_wdata;
          wstrb_n     = i_mm_wstrb;
          w_state_n   = W_REQ;
        end
      end
      W_REQ: begin
        if (aw_hs) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (w_hs) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        // both channels may finish on the same edge
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          bready_n  = 1'b1;
          w_state_n = W_RESP;
        end
      end
      W_RESP: begin
        if (i_axi_bvalid && o_axi_bready) begin
          bready_n    = 1'b0;
          wresp_n     = i_axi_bresp;
          wdone_n     = 1'b1;
          mm_wready_n = 1'b1;
          w_state_n   = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Read engine
  always_comb begin
    r_state_n   = r_state;
    mm_rready_n = o_mm_rready;
    arvalid_n   = o_axi_arvalid;
    rready_n    = o_axi_rready;
    araddr_n    = o_axi_araddr;
    arprot_n    = o_axi_arprot;
    rdata_n     = o_mm_rdata;
    rresp_n     = o_mm_rresp;
    rdone_n     = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        mm_rready_n = 1'b1;
        if (o_mm_rready && i_mm_rvalid) begin
          mm_rready_n = 1'b0;
          arvalid_n   = 1'b1;
          araddr_n    = ADDR_WIDTH'(i_mm_raddr) << ALIGN;
          arprot_n    = i_mm_rprot;
          r_state_n   = R_ADDR;
        end
      end
      R_ADDR: begin
        if (i_axi_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (i_axi_rvalid) begin
          rready_n    = 1'b0;
          rdata_n     = i_axi_rdata;
          rresp_n     = i_axi_rresp;
          rdone_n     = 1'b1;
          mm_rready_n = 1'b1;
          r_state_n   = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state       <= W_IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      o_mm_wready   <= 1'b0;
      o_axi_awvalid <= 1'b0;
      o_axi_wvalid  <= 1'b0;
      o_axi_bready  <= 1'b0;
      o_axi_awaddr  <= '0;
      o_axi_awprot  <= '0;
      o_axi_wdata   <= '0;
      o_axi_wstrb   <= '0;
      o_mm_wresp    <= '0;
      o_mm_wdone    <= 1'b0;
      r_state       <= R_IDLE;
      o_mm_rready   <= 1'b0;
      o_axi_arvalid <= 1'b0;
      o_axi_rready  <= 1'b0;
      o_axi_araddr  <= '0;
      o_axi_arprot  <= '0;
      o_mm_rdata    <= '0;
      o_mm_rresp    <= '0;
      o_mm_rdone    <= 1'b0;
    end else begin
      w_state       <= w_state_n;
      aw_done       <= aw_done_n;
      w_done        <= w_done_n;
      o_mm_wready   <= mm_wready_n;
      o_axi_awvalid <= awvalid_n;
      o_axi_wvalid  <= wvalid_n;
      o_axi_bready  <= bready_n;
      o_axi_awaddr  <= awaddr_n;
      o_axi_awprot  <= awprot_n;
      o_axi_wdata   <= wdata_n;
      o_axi_wstrb   <= wstrb_n;
      o_mm_wresp    <= wresp_n;
      o_mm_wdone    <= wdone_n;
      r_state       <= r_state_n;
      o_mm_rready   <= mm_rready_n;
      o_axi_arvalid <= arvalid_n;
      o_axi_rready  <= rready_n;
      o_axi_araddr  <= araddr_n;
      o_axi_arprot  <= arprot_n;
      o_mm_rdata    <= rdata_n;
      o_mm_rresp    <= rresp_n;
      o_mm_rdone    <= rdone_n;
    end
  end

endmodule

// File: tb/tb_axi_lite_mm_master.sv
// Bench for axi_lite_mm_master: table-driven write/read vectors
// against a delay-configurable AXI slave, plus timing corner cases.
module tb_axi_lite_mm_master;

  logic        clk = 1'b0;
  logic        areset;
  logic        i_mm_wvalid;
  logic        o_mm_wready;
  logic [60:0] i_mm_waddr;
  logic [63:0] i_mm_wdata;
  logic [7:0]  i_mm_wstrb;
  logic [2:0]  i_mm_wprot;
  logic        o_mm_wdone;
  logic [1:0]  o_mm_wresp;
  logic        i_mm_rvalid;
  logic        o_mm_rready;
  logic [60:0] i_mm_raddr;
  logic [2:0]  i_mm_rprot;
  logic        o_mm_rdone;
  logic [63:0] o_mm_rdata;
  logic [1:0]  o_mm_rresp;
  logic        awvalid, awready;
  logic [63:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [63:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  axi_lite_mm_master dut (
    .aclk(clk), .areset(areset),
    .i_mm_wvalid(i_mm_wvalid), .o_mm_wready(o_mm_wready),
    .i_mm_waddr(i_mm_waddr), .i_mm_wdata(i_mm_wdata),
    .i_mm_wstrb(i_mm_wstrb), .i_mm_wprot(i_mm_wprot),
    .o_mm_wdone(o_mm_wdone), .o_mm_wresp(o_mm_wresp),
    .i_mm_rvalid(i_mm_rvalid), .o_mm_rready(o_mm_rready),
    .i_mm_raddr(i_mm_raddr), .i_mm_rprot(i_mm_rprot),
    .o_mm_rdone(o_mm_rdone), .o_mm_rdata(o_mm_rdata),
    .o_mm_rresp(o_mm_rresp),
    .o_axi_awvalid(awvalid), .i_axi_awready(awready),
    .o_axi_awaddr(awaddr), .o_axi_awprot(awprot),
    .o_axi_wvalid(wvalid), .i_axi_wready(wready),
    .o_axi_wdata(wdata), .o_axi_wstrb(wstrb),
    .i_axi_bvalid(bvalid), .o_axi_bready(bready),
    .i_axi_bresp(bresp),
    .o_axi_arvalid(arvalid), .i_axi_arready(arready),
    .o_axi_araddr(araddr), .o_axi_arprot(arprot),
    .i_axi_rvalid(rvalid), .o_axi_rready(rready),
    .i_axi_rdata(rdata), .i_axi_rresp(rresp)
  );

  // slave configuration, set by the main sequence
  int          cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [63:0] cfg_rdata;

  // slave: ready/valid after N wait cycles, driven on negedge
  int aw_c, w_c, b_c, ar_c, r_c;
  initial begin
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
  end
  always @(negedge clk) begin
    if (awvalid) begin awready = (aw_c >= cfg_aw_d); aw_c++; end
    else begin awready = 0; aw_c = 0; end
    if (wvalid) begin wready = (w_c >= cfg_w_d); w_c++; end
    else begin wready = 0; w_c = 0; end
    if (bready) begin bvalid = (b_c >= cfg_b_d); b_c++; end
    else begin bvalid = 0; b_c = 0; end
    bresp = bvalid ? cfg_bresp : 2'b01;
    if (arvalid) begin arready = (ar_c >= cfg_ar_d); ar_c++; end
    else begin arready = 0; ar_c = 0; end
    if (rready) begin rvalid = (r_c >= cfg_r_d); r_c++; end
    else begin rvalid = 0; r_c = 0; end
    rdata = rvalid ? cfg_rdata : ~cfg_rdata;
    rresp = rvalid ? cfg_rresp : 2'b01;
  end

  // monitor on the active edge
  int aw_hi, w_hi, ar_hi, aw_hs, w_hs, ar_hs, wdone_cnt, rdone_cnt, viol;
  logic [63:0] aw_addr_s, w_data_s, ar_addr_s;
  logic [7:0]  w_strb_s;
  logic [2:0]  aw_prot_s, ar_prot_s;
  logic        pend;
  initial begin
    aw_hi = 0; w_hi = 0; ar_hi = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
    wdone_cnt = 0; rdone_cnt = 0; viol = 0; pend = 0;
    aw_addr_s = 0; w_data_s = 0; ar_addr_s = 0; w_strb_s = 0;
    aw_prot_s = 0; ar_prot_s = 0;
  end
  always @(posedge clk) begin
    if (awvalid && pend) viol++;
    if (awvalid) aw_hi++;
    if (wvalid) w_hi++;
    if (arvalid) ar_hi++;
    if (awvalid && awready) begin
      aw_hs++; aw_addr_s = awaddr; aw_prot_s = awprot; pend = 1;
    end
    if (wvalid && wready) begin
      w_hs++; w_data_s = wdata; w_strb_s = wstrb;
    end
    if (arvalid && arready) begin
      ar_hs++; ar_addr_s = araddr; ar_prot_s = arprot;
    end
    if (bvalid && bready) pend = 0;
    if (areset) pend = 0;
    if (o_mm_wdone) wdone_cnt++;
    if (o_mm_rdone) rdone_cnt++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_wready();
    for (int i = 0; i < 50; i++) begin
      if (o_mm_wready) return;
      @(negedge clk);
    end
    check("wready_timeout", 0, 1);
  endtask

  task automatic wait_rready();
    for (int i = 0; i < 50; i++) begin
      if (o_mm_rready) return;
      @(negedge clk);
    end
    check("rready_timeout", 0, 1);
  endtask

  task automatic wait_wdone(input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      @(negedge clk);
      n++;
      if (o_mm_wdone) return;
    end
    check("wdone_timeout", 0, 1);
  endtask

  task automatic wait_rdone(input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      @(negedge clk);
      n++;
      if (o_mm_rdone) return;
    end
    check("rdone_timeout", 0, 1);
  endtask

  typedef struct {
    logic [60:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [2:0]  prot;
    int          aw_d, w_d, b_d;
    logic [1:0]  bresp;
    logic [63:0] exp_addr;
    int          exp_aw_cyc, exp_w_cyc;
  } wvec_t;

  typedef struct {
    logic [60:0] addr;
    logic [2:0]  prot;
    int          ar_d, r_d;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [63:0] exp_addr;
    int          exp_ar_cyc;
  } rvec_t;

  task automatic run_write(input wvec_t v);
    int n, aw0, w0, awh0, wh0, d0;
    cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_b_d = v.b_d;
    cfg_bresp = v.bresp;
    wait_wready();
    aw0 = aw_hi; w0 = w_hi; awh0 = aw_hs; wh0 = w_hs; d0 = wdone_cnt;
    i_mm_waddr = v.addr; i_mm_wdata = v.data;
    i_mm_wstrb = v.strb; i_mm_wprot = v.prot;
    i_mm_wvalid = 1;
    @(negedge clk);
    i_mm_wvalid = 0;
    wait_wdone(60, n);
    check("w_wready_at_done", 64'(o_mm_wready), 1);
    check("w_wresp", 64'(o_mm_wresp), 64'(v.bresp));
    @(negedge clk);
    check("w_done_one_cycle", 64'(o_mm_wdone), 0);
    check("w_wresp_held", 64'(o_mm_wresp), 64'(v.bresp));
    check("w_awaddr", aw_addr_s, v.exp_addr);
    check("w_awprot", 64'(aw_prot_s), 64'(v.prot));
    check("w_wdata", w_data_s, v.data);
    check("w_wstrb", 64'(w_strb_s), 64'(v.strb));
    check("w_aw_cycles", 64'(aw_hi - aw0), 64'(v.exp_aw_cyc));
    check("w_w_cycles", 64'(w_hi - w0), 64'(v.exp_w_cyc));
    check("w_handshakes", 64'((aw_hs - awh0) + (w_hs - wh0)), 2);
    check("w_done_count", 64'(wdone_cnt - d0), 1);
  endtask

  task automatic run_read(input rvec_t v);
    int n, ar0, arh0, d0;
    cfg_ar_d = v.ar_d; cfg_r_d = v.r_d;
    cfg_rdata = v.rdata; cfg_rresp = v.rresp;
    wait_rready();
    ar0 = ar_hi; arh0 = ar_hs; d0 = rdone_cnt;
    i_mm_raddr = v.addr; i_mm_rprot = v.prot;
    i_mm_rvalid = 1;
    @(negedge clk);
    i_mm_rvalid = 0;
    wait_rdone(60, n);
    check("r_rready_at_done", 64'(o_mm_rready), 1);
    check("r_rdata", o_mm_rdata, v.rdata);
    check("r_rresp", 64'(o_mm_rresp), 64'(v.rresp));
    repeat (3) @(negedge clk);
    check("r_rdata_held", o_mm_rdata, v.rdata);
    check("r_rresp_held", 64'(o_mm_rresp), 64'(v.rresp));
    check("r_araddr", ar_addr_s, v.exp_addr);
    check("r_arprot", 64'(ar_prot_s), 64'(v.prot));
    check("r_ar_cycles", 64'(ar_hi - ar0), 64'(v.exp_ar_cyc));
    check("r_ar_hs", 64'(ar_hs - arh0), 1);
    check("r_done_count", 64'(rdone_cnt - d0), 1);
  endtask

  wvec_t wv[4];
  rvec_t rv[3];

  initial begin
    int n, d0, r0, awh0, wh0, acc, cyc;
    logic acc_now;

    wv[0] = '{61'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 3'd0,
              0, 0, 0, 2'b00, 64'h80, 1, 1};
    wv[1] = '{61'h3, 64'h0000_0000_0000_1111, 8'h0F, 3'b101,
              5, 0, 2, 2'b10, 64'h18, 6, 1};
    wv[2] = '{61'h1FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80,
              3'b111, 0, 4, 0, 2'b11, 64'hFFFF_FFFF_FFFF_FFF8, 1, 5};
    wv[3] = '{61'h7, 64'h0123_4567_89AB_CDEF, 8'hA5, 3'b010,
              3, 3, 1, 2'b01, 64'h38, 4, 4};
    rv[0] = '{61'h3, 3'b010, 0, 4, 64'h1234, 2'b10, 64'h18, 1};
    rv[1] = '{61'h0, 3'b000, 2, 0, 64'hA5A5_5A5A_0F0F_F0F0,
              2'b00, 64'h0, 3};
    rv[2] = '{61'hABC, 3'b111, 0, 1, 64'h8000_0000_0000_0001,
              2'b11, 64'h55E0, 1};

    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0;
    cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
    i_mm_wvalid = 0; i_mm_waddr = 0; i_mm_wdata = 0;
    i_mm_wstrb = 0; i_mm_wprot = 0;
    i_mm_rvalid = 0; i_mm_raddr = 0; i_mm_rprot = 0;
    areset = 1;

    // reset state, commands while in reset ignored
    @(negedge clk);
    i_mm_wvalid = 1; i_mm_rvalid = 1;
    repeat (2) @(negedge clk);
    check("rst_mm_readies", {62'd0, o_mm_wready, o_mm_rready}, 0);
    check("rst_valids",
      {58'd0, awvalid, wvalid, bready, arvalid, rready, o_mm_wdone}, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_araddr", araddr, 0);
    check("rst_rdata", o_mm_rdata, 0);
    check("rst_resps",
      {55'd0, o_mm_rdone, o_mm_wresp, o_mm_rresp, awprot, wstrb[0]}, 0);
    i_mm_wvalid = 0; i_mm_rvalid = 0;
    areset = 0;
    #1;
    check("rel_wready_low", 64'(o_mm_wready), 0);
    @(negedge clk);
    check("rel_readies_up", {62'd0, o_mm_wready, o_mm_rready}, 3);
    check("rel_no_txn", 64'(aw_hs + ar_hs), 0);

    // single write, exact cycle timing
    i_mm_waddr = 61'h10; i_mm_wdata = 64'hDEADBEEF_CAFEF00D;
    i_mm_wstrb = 8'hFF; i_mm_wprot = 0; i_mm_wvalid = 1;
    @(negedge clk);
    i_mm_wvalid = 0;
    check("t_e_valids", {61'd0, awvalid, wvalid, o_mm_wready}, 6);
    check("t_e_awaddr", awaddr, 64'h80);
    @(negedge clk);
    check("t_e1_bready", {62'd0, bready, awvalid}, 2);
    @(negedge clk);
    check("t_e2_done", {62'd0, o_mm_wdone, o_mm_wready}, 3);
    @(negedge clk);
    check("t_e3_done_low", 64'(o_mm_wdone), 0);

    for (int i = 0; i < 4; i++) run_write(wv[i]);
    for (int i = 0; i < 3; i++) run_read(rv[i]);

    // concurrent read and write, AR stalled
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_bresp = 2'b00;
    cfg_ar_d = 20; cfg_r_d = 0;
    cfg_rdata = 64'h5555_6666_7777_8888; cfg_rresp = 2'b00;
    d0 = wdone_cnt; r0 = rdone_cnt;
    i_mm_waddr = 61'h20; i_mm_wdata = 64'h42; i_mm_wstrb = 8'h01;
    i_mm_raddr = 61'h21; i_mm_rprot = 0;
    i_mm_wvalid = 1; i_mm_rvalid = 1;
    @(negedge clk);
    i_mm_wvalid = 0; i_mm_rvalid = 0;
    wait_wdone(10, n);
    check("cc_wdone_latency", 64'(n), 2);
    check("cc_ar_still_stalled", {62'd0, arvalid, o_mm_rdone}, 2);
    wait_rdone(40, n);
    check("cc_rdata", o_mm_rdata, 64'h5555_6666_7777_8888);
    check("cc_araddr", ar_addr_s, 64'h108);
    @(negedge clk);
    check("cc_done_counts", 64'({wdone_cnt - d0, rdone_cnt - r0}),
          64'({32'd1, 32'd1}));

    // reset in the middle of a write
    cfg_aw_d = 10; cfg_ar_d = 0;
    d0 = wdone_cnt;
    wait_wready();
    i_mm_waddr = 61'h5; i_mm_wvalid = 1;
    @(negedge clk);
    i_mm_wvalid = 0;
    @(negedge clk);
    check("mid_awvalid_up", 64'(awvalid), 1);
    areset = 1;
    #1;
    check("mid_rst_drop",
      {59'd0, awvalid, wvalid, bready, o_mm_wready, o_mm_rready}, 0);
    repeat (2) @(negedge clk);
    areset = 0;
    #1;
    check("mid_rel_still_low", {62'd0, o_mm_wready, o_mm_rready}, 0);
    @(negedge clk);
    check("mid_readies_up", {62'd0, o_mm_wready, o_mm_rready}, 3);
    repeat (2) @(negedge clk);
    check("mid_no_wdone", 64'(wdone_cnt - d0), 0);
    check("mid_awvalid_idle", 64'(awvalid), 0);
    run_write(wv[0]);

    // back-to-back writes with wvalid held
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0;
    wait_wready();
    d0 = wdone_cnt; awh0 = aw_hs; wh0 = w_hs;
    acc = 0; cyc = 0;
    i_mm_waddr = 61'h40; i_mm_wdata = 64'd1; i_mm_wvalid = 1;
    while (acc < 3 && cyc < 40) begin
      acc_now = o_mm_wready;
      @(negedge clk);
      cyc++;
      if (acc_now) begin
        acc++;
        i_mm_wdata = 64'(acc + 1);
        if (acc == 3) i_mm_wvalid = 0;
      end
    end
    i_mm_wvalid = 0;
    repeat (6) @(negedge clk);
    check("b2b_aw_hs", 64'(aw_hs - awh0), 3);
    check("b2b_w_hs", 64'(w_hs - wh0), 3);
    check("b2b_wdone", 64'(wdone_cnt - d0), 3);
    check("b2b_last_wdata", w_data_s, 3);
    check("aw_before_b_violations", 64'(viol), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
